// File: rtl/count_arb_ctrl.sv
// count_arb_ctrl: round-robin arbiter and sequencer for one shared WIDTH-bit
// up-counter. A granted requester gets a run of (len+1) counter cycles, after
// which it receives a one-cycle done pulse. Dropping req mid-run aborts the run.
// All outputs are registered.
module count_arb_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [WIDTH-1:0] q,
  output logic [1:0]       done
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] len_r;   // run length frozen at grant
  logic             owner;   // requester currently holding the counter
  logic             ptr;     // round-robin pointer: requester favoured on contention
  logic             win;     // requester that would win a grant this cycle

  // Pick the winner among the current requests; the pointer breaks ties.
  always_comb begin
    // NOTE: assigning a default before any branch keeps this purely
    // combinational; a path that leaves win unassigned would infer a latch.
    win = ptr;
    if (req == 2'b01) begin
      win = 1'b0;
    end else if (req == 2'b10) begin
      win = 1'b1;
    end
  end

  // Arbitration FSM: grants in IDLE, sequences the count and ends the run in COUNT.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    if (rst) begin
      state <= IDLE;
      gnt   <= 2'b00;
      busy  <= 1'b0;
      q     <= '0;
      done  <= 2'b00;
      len_r <= '0;
      owner <= 1'b0;
      ptr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 2'b00;
          if (req != 2'b00) begin
            gnt   <= win ? 2'b10 : 2'b01;
            busy  <= 1'b1;
            q     <= '0;
            len_r <= win ? len1 : len0;
            owner <= win;
            state <= COUNT;
          end
        end

        COUNT: begin
          done <= 2'b00;
          if (!req[owner]) begin
            // Abort: release the counter without signalling completion.
            gnt   <= 2'b00;
            busy  <= 1'b0;
            q     <= '0;
            ptr   <= ~owner;
            state <= IDLE;
          end else if (q == len_r) begin
            // Terminal count: release and pulse done to the owner.
            done  <= owner ? 2'b10 : 2'b01;
            gnt   <= 2'b00;
            busy  <= 1'b0;
            q     <= '0;
            ptr   <= ~owner;
            state <= IDLE;
          end else begin
            q <= q + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_arb_ctrl.sv
// Directed testbench for count_arb_ctrl. Each step drives inputs, pushes the
// expected post-edge outputs into a scoreboard queue, and after the edge pops
// and compares them against the DUT.
module tb_count_arb_ctrl;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req;
  logic [WIDTH-1:0] len0;
  logic [WIDTH-1:0] len1;
  logic [1:0]       gnt;
  logic             busy;
  logic [WIDTH-1:0] q;
  logic [1:0]       done;

  count_arb_ctrl #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .len0 (len0),
    .len1 (len1),
    .gnt  (gnt),
    .busy (busy),
    .q    (q),
    .done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    logic [1:0]       gnt;
    logic [WIDTH-1:0] q;
    logic [1:0]       done;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Pop one expectation and compare every output against it.
  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty observed=none expected=entry");
    end else begin
      e = sb.pop_front();
      compared++;
      assert (gnt === e.gnt) else begin
        mismatched++;
        $error("FAIL %s gnt observed=%b expected=%b", e.tag, gnt, e.gnt);
      end
      compared++;
      assert (busy === (|e.gnt)) else begin
        mismatched++;
        $error("FAIL %s busy observed=%b expected=%b", e.tag, busy, |e.gnt);
      end
      compared++;
      assert (q === e.q) else begin
        mismatched++;
        $error("FAIL %s q observed=%0d expected=%0d", e.tag, q, e.q);
      end
      compared++;
      assert (done === e.done) else begin
        mismatched++;
        $error("FAIL %s done observed=%b expected=%b", e.tag, done, e.done);
      end
    end
  endtask

  // Drive one cycle of inputs, record what the DUT must show after the edge.
  task automatic step(input logic r, input logic [1:0] rq,
                      input logic [WIDTH-1:0] l0, input logic [WIDTH-1:0] l1,
                      input string tag, input logic [1:0] eg,
                      input logic [WIDTH-1:0] eq, input logic [1:0] ed);
    exp_t e;
    rst  = r;
    req  = rq;
    len0 = l0;
    len1 = l1;
    e.tag  = tag;
    e.gnt  = eg;
    e.q    = eq;
    e.done = ed;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    rst  = 1'b1;
    req  = 2'b00;
    len0 = '0;
    len1 = '0;

    // Reset state
    step(1, 2'b00, 4'd0, 4'd0, "reset0", 2'b00, 4'd0, 2'b00);
    step(1, 2'b11, 4'd3, 4'd3, "reset1", 2'b00, 4'd0, 2'b00);
    step(0, 2'b00, 4'd0, 4'd0, "idle",   2'b00, 4'd0, 2'b00);

    // Single run: requester 0, len0=3
    step(0, 2'b01, 4'd3, 4'd0, "single_q0",   2'b01, 4'd0, 2'b00);
    step(0, 2'b01, 4'd3, 4'd0, "single_q1",   2'b01, 4'd1, 2'b00);
    step(0, 2'b01, 4'd3, 4'd0, "single_q2",   2'b01, 4'd2, 2'b00);
    step(0, 2'b01, 4'd3, 4'd0, "single_q3",   2'b01, 4'd3, 2'b00);
    step(0, 2'b01, 4'd3, 4'd0, "single_done", 2'b00, 4'd0, 2'b01);
    step(0, 2'b00, 4'd3, 4'd0, "single_after",2'b00, 4'd0, 2'b00);

    // Contention from reset: pointer favours 0
    step(1, 2'b00, 4'd0, 4'd0, "cont_reset", 2'b00, 4'd0, 2'b00);
    step(0, 2'b11, 4'd2, 4'd1, "cont_g0_q0", 2'b01, 4'd0, 2'b00);
    step(0, 2'b11, 4'd2, 4'd1, "cont_g0_q1", 2'b01, 4'd1, 2'b00);
    step(0, 2'b11, 4'd2, 4'd1, "cont_g0_q2", 2'b01, 4'd2, 2'b00);
    step(0, 2'b11, 4'd2, 4'd1, "cont_done0", 2'b00, 4'd0, 2'b01);
    // Both still requesting in the done cycle: requester 1 wins
    step(0, 2'b11, 4'd2, 4'd1, "cont_g1_q0", 2'b10, 4'd0, 2'b00);
    step(0, 2'b11, 4'd2, 4'd1, "cont_g1_q1", 2'b10, 4'd1, 2'b00);
    step(0, 2'b11, 4'd2, 4'd1, "cont_done1", 2'b00, 4'd0, 2'b10);
    // After serving 1 the pointer favours 0 again
    step(0, 2'b11, 4'd2, 4'd1, "cont_regrant0", 2'b01, 4'd0, 2'b00);
    step(1, 2'b00, 4'd0, 4'd0, "cont_clear",    2'b00, 4'd0, 2'b00);

    // Zero length: requester 1, len1=0
    step(0, 2'b10, 4'd9, 4'd0, "zero_g1",    2'b10, 4'd0, 2'b00);
    step(0, 2'b10, 4'd9, 4'd0, "zero_done",  2'b00, 4'd0, 2'b10);
    step(0, 2'b00, 4'd9, 4'd0, "zero_after", 2'b00, 4'd0, 2'b00);

    // Abort: pointer favours 0; requester 1 toggles without effect
    step(0, 2'b11, 4'd7, 4'd1, "abort_q0", 2'b01, 4'd0, 2'b00);
    step(0, 2'b01, 4'd7, 4'd1, "abort_q1", 2'b01, 4'd1, 2'b00);
    step(0, 2'b11, 4'd7, 4'd1, "abort_q2", 2'b01, 4'd2, 2'b00);
    step(0, 2'b11, 4'd7, 4'd1, "abort_q3", 2'b01, 4'd3, 2'b00);
    step(0, 2'b10, 4'd7, 4'd1, "abort_drop", 2'b00, 4'd0, 2'b00);
    step(0, 2'b10, 4'd7, 4'd1, "abort_g1",   2'b10, 4'd0, 2'b00);
    step(0, 2'b10, 4'd7, 4'd1, "abort_g1_q1",2'b10, 4'd1, 2'b00);
    step(0, 2'b10, 4'd7, 4'd1, "abort_done1",2'b00, 4'd0, 2'b10);
    step(0, 2'b00, 4'd7, 4'd1, "abort_after",2'b00, 4'd0, 2'b00);

    // Reset mid-run at q=2 with len=5: no done pulse
    step(0, 2'b01, 4'd5, 4'd0, "midrst_q0", 2'b01, 4'd0, 2'b00);
    step(0, 2'b01, 4'd5, 4'd0, "midrst_q1", 2'b01, 4'd1, 2'b00);
    step(0, 2'b01, 4'd5, 4'd0, "midrst_q2", 2'b01, 4'd2, 2'b00);
    step(1, 2'b01, 4'd5, 4'd0, "midrst_rst",  2'b00, 4'd0, 2'b00);
    step(0, 2'b00, 4'd5, 4'd0, "midrst_after",2'b00, 4'd0, 2'b00);

    // Full length with len0 changed to 2 mid-run
    for (int i = 0; i < 16; i++) begin
      step(0, 2'b01, (i < 3) ? 4'd15 : 4'd2, 4'd0, "full_run",
           2'b01, 4'(i), 2'b00);
    end
    step(0, 2'b01, 4'd2, 4'd0, "full_done",  2'b00, 4'd0, 2'b01);
    step(0, 2'b00, 4'd2, 4'd0, "full_after", 2'b00, 4'd0, 2'b00);

    if (sb.size() != 0) begin
      mismatched++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
